// File: rtl/pll_reset_seq.sv
// Reset and lock supervisor for the radio rPLL: filters PLL lock, releases
// datapath resets in a fixed order, and re-resets the PLL if lock never arrives.
module pll_reset_seq #(
  parameter int RST_CYC   = 16,
  parameter int LOCK_FILT = 1024,
  parameter int TIMEOUT   = 65536,
  parameter int STAGE_GAP = 256,
  parameter int NSTAGE    = 3,
  parameter int CNT_W     = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lock,
  output logic              pll_reset,
  output logic [NSTAGE-1:0] stage_rst_n,
  output logic              ready,
  output logic [1:0]        state,
  output logic [7:0]        relock_cnt,
  output logic [7:0]        retry_cnt
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(NSTAGE * STAGE_GAP - 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  hi_reg;
  logic              pll_reset_reg;
  logic [NSTAGE-1:0] stage_reg;
  logic              ready_reg;
  logic [7:0]        relock_reg;
  logic [7:0]        retry_reg;
  logic              lock_meta_reg;
  logic              lock_s;

  // lock comes from the PLL analog block and is asynchronous to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_reg <= 1'b0;
      lock_s        <= 1'b0;
    end else begin
      lock_meta_reg <= lock;
      lock_s        <= lock_meta_reg;
    end
  end

  // stage_set[k] marks the edge at which stage k deasserts while in RELEASE
  logic [NSTAGE-1:0] stage_set;
  assign stage_set[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < NSTAGE; gi++) begin : g_stage
      localparam logic [CNT_W-1:0] HIT = CNT_W'(gi * STAGE_GAP - 1);
      assign stage_set[gi] = (cnt_reg == HIT);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= PLL_RST;
      cnt_reg       <= '0;
      hi_reg        <= '0;
      pll_reset_reg <= 1'b1;
      stage_reg     <= '0;
      ready_reg     <= 1'b0;
      relock_reg    <= 8'd0;
      retry_reg     <= 8'd0;
    end else if ((state_reg == RELEASE || state_reg == RUN) && !lock_s) begin
      // lock lost: drop every stage at once and wait for relock without a PLL reset
      state_reg <= WAIT_LOCK;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      stage_reg <= '0;
      ready_reg <= 1'b0;
      if (relock_reg != 8'hFF) relock_reg <= relock_reg + 8'd1;
    end else begin
      case (state_reg)
        PLL_RST: begin
          if (cnt_reg == RST_LAST) begin
            state_reg     <= WAIT_LOCK;
            cnt_reg       <= '0;
            pll_reset_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // lock filter completion takes priority over a coincident timeout
          if (lock_s && hi_reg == FILT_LAST) begin
            state_reg <= RELEASE;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            stage_reg <= NSTAGE'(1);
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_reg     <= PLL_RST;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            pll_reset_reg <= 1'b1;
            if (retry_reg != 8'hFF) retry_reg <= retry_reg + 8'd1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            hi_reg  <= lock_s ? hi_reg + 1'b1 : '0;
          end
        end
        RELEASE: begin
          if (cnt_reg == REL_LAST) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            ready_reg <= 1'b1;
            stage_reg <= '1;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
            stage_reg <= stage_reg | stage_set;
          end
        end
        RUN: begin
          cnt_reg <= '0;
        end
        default: begin
          state_reg <= PLL_RST;
        end
      endcase
    end
  end

  assign pll_reset   = pll_reset_reg;
  assign stage_rst_n = stage_reg;
  assign ready       = ready_reg;
  assign state       = state_reg;
  assign relock_cnt  = relock_reg;
  assign retry_cnt   = retry_reg;

endmodule
